// File: rtl/bit_deserializer_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserializer.
// The bit counter and the output length field both need to hold the value WIDTH.
package bit_deserializer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    function automatic int len_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/bit_deserializer.sv
// Collects a serial MSB-first bit stream into WIDTH-bit words on a valid/ready port.
// A word that completes while the output slot is busy is parked in the assembly register.
//
// state | meaning
// FILL  | accepting bits; completed words go straight to the output register
// PEND  | a justified word is parked in assembly, waiting for the output slot
module bit_deserializer
    import bit_deserializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic                     data_i,
    input  logic                     data_val_i,
    input  logic                     data_last_i,
    output logic                     data_rdy_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [len_w(WIDTH)-1:0]  data_len_o,
    output logic                     data_val_o,
    input  logic                     data_rdy_i
);

    localparam int             LW      = len_w(WIDTH);
    localparam logic [LW-1:0]  WIDTH_L = LW'(WIDTH);

    state_t            state;
    logic [WIDTH-1:0]  assembly;
    logic [LW-1:0]     cnt;

    logic              accept;
    logic              slot_free;
    logic              complete;
    logic [WIDTH-1:0]  shifted;
    logic [LW-1:0]     cnt_nxt;
    logic [WIDTH-1:0]  justified;

    // A partial word of n bits sits in the low n bits after shifting; move it to the top.
    function automatic logic [WIDTH-1:0] left_justify(input logic [WIDTH-1:0] word,
                                                      input logic [LW-1:0]    n);
        return word << (WIDTH_L - n);
    endfunction

    assign data_rdy_o = srst_i & (state == FILL);
    assign accept     = data_val_i & data_rdy_o;
    assign slot_free  = ~data_val_o | data_rdy_i;
    assign shifted    = {assembly[WIDTH-2:0], data_i};
    assign cnt_nxt    = cnt + LW'(1);
    assign complete   = accept & ((cnt_nxt == WIDTH_L) | data_last_i);
    assign justified  = left_justify(shifted, cnt_nxt);

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state      <= FILL;
            assembly   <= '0;
            cnt        <= '0;
            data_o     <= '0;
            data_len_o <= '0;
            data_val_o <= 1'b0;
        end else begin
            // Default drop of valid on handshake; a same-edge load below overrides it.
            if (data_val_o && data_rdy_i) begin
                data_val_o <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (accept) begin
                        if (complete) begin
                            if (slot_free) begin
                                data_o     <= justified;
                                data_len_o <= cnt_nxt;
                                data_val_o <= 1'b1;
                                assembly   <= '0;
                                cnt        <= '0;
                            end else begin
                                assembly <= justified;
                                cnt      <= cnt_nxt;
                                state    <= PEND;
                            end
                        end else begin
                            assembly <= shifted;
                            cnt      <= cnt_nxt;
                        end
                    end
                end

                PEND: begin
                    if (slot_free) begin
                        data_o     <= assembly;
                        data_len_o <= cnt;
                        data_val_o <= 1'b1;
                        assembly   <= '0;
                        cnt        <= '0;
                        state      <= FILL;
                    end
                end

                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_deserializer.sv
// Self-checking bench for bit_deserializer (WIDTH=8): directed vector table, hand-written
// stall/reset sequences, and randomized streams checked against a bit-queue reference model.
module tb_bit_deserializer;

    localparam int WIDTH = 8;
    localparam int LW    = $clog2(WIDTH) + 1;

    logic             clk;
    logic             srst_i;
    logic             data_i;
    logic             data_val_i;
    logic             data_last_i;
    logic             data_rdy_o;
    logic [WIDTH-1:0] data_o;
    logic [LW-1:0]    data_len_o;
    logic             data_val_o;
    logic             data_rdy_i;

    int total = 0;
    int bad   = 0;

    bit_deserializer #(.WIDTH(WIDTH)) dut (
        .clk_i       (clk),
        .srst_i      (srst_i),
        .data_i      (data_i),
        .data_val_i  (data_val_i),
        .data_last_i (data_last_i),
        .data_rdy_o  (data_rdy_o),
        .data_o      (data_o),
        .data_len_o  (data_len_o),
        .data_val_o  (data_val_o),
        .data_rdy_i  (data_rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             din;
        logic             val;
        logic             last;
        logic             rdy;
        logic             e_val;
        logic [WIDTH-1:0] e_data;
        logic [LW-1:0]    e_len;
        logic             e_rdy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, take the edge, land 1 time unit after it.
    task automatic cyc(input logic din, input logic val, input logic last, input logic rdy);
        data_i      = din;
        data_val_i  = val;
        data_last_i = last;
        data_rdy_i  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            cyc(w[i], 1'b1, 1'b0, rdy);
        end
    endtask

    task automatic do_reset(input string tag);
        srst_i      = 1'b0;
        data_val_i  = 1'b0;
        data_last_i = 1'b0;
        data_i      = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_val"},  32'(data_val_o), 32'd0);
        check({tag, "_data"}, 32'(data_o),     32'd0);
        check({tag, "_len"},  32'(data_len_o), 32'd0);
        check({tag, "_rdy_low"}, 32'(data_rdy_o), 32'd0);
        srst_i = 1'b1;
        #1;
        check({tag, "_rdy_rel"}, 32'(data_rdy_o), 32'd1);
    endtask

    // Reference model: accepted bits accumulate in a queue; a word is the queue contents
    // placed MSB-first at the top of the output, emitted when full or on last.
    task automatic run_random(input int nwords, input bit rand_rdy, input string tag);
        bit               cur[$];
        logic [WIDTH-1:0] exp_w[$];
        logic [LW-1:0]    exp_l[$];
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] ew;
        logic             acc;
        logic             hs;
        int               got    = 0;
        int               cycles = 0;
        int               stalls = 0;
        while (got < nwords && cycles < 8000) begin
            data_val_i  = ($urandom_range(0, 3) != 0);
            data_i      = 1'($urandom);
            data_last_i = ($urandom_range(0, 9) == 0);
            data_rdy_i  = rand_rdy ? 1'($urandom) : 1'b1;
            #1;
            acc = data_val_i & data_rdy_o;
            hs  = data_val_o & data_rdy_i;
            if (!data_rdy_o) stalls++;
            if (hs) begin
                if (exp_w.size() == 0) begin
                    check({tag, "_spurious"}, 32'd1, 32'd0);
                end else begin
                    ew = exp_w.pop_front();
                    check({tag, "_word"}, 32'(data_o), 32'(ew));
                    check({tag, "_len"},  32'(data_len_o), 32'(exp_l.pop_front()));
                    check({tag, "_popcount"}, 32'($countones(data_o)), 32'($countones(ew)));
                end
                got++;
            end
            if (acc) begin
                cur.push_back(data_i);
                if (cur.size() == WIDTH || data_last_i) begin
                    w = '0;
                    for (int i = 0; i < cur.size(); i++) w[WIDTH-1-i] = cur[i];
                    exp_w.push_back(w);
                    exp_l.push_back(LW'(cur.size()));
                    cur.delete();
                end
            end
            if (exp_w.size() > 2) check({tag, "_inflight"}, 32'(exp_w.size()), 32'd2);
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_words_done"}, 32'(got), 32'(nwords));
        if (!rand_rdy) check({tag, "_no_stall"}, 32'(stalls), 32'd0);
        data_val_i = 1'b0;
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic din, input logic val, input logic last,
                                input logic rdy, input logic e_val,
                                input logic [WIDTH-1:0] e_data, input logic [LW-1:0] e_len,
                                input logic e_rdy);
        vec_t v;
        v.din = din; v.val = val; v.last = last; v.rdy = rdy;
        v.e_val = e_val; v.e_data = e_data; v.e_len = e_len; v.e_rdy = e_rdy;
        return v;
    endfunction

    initial begin
        srst_i      = 1'b0;
        data_i      = 1'b0;
        data_val_i  = 1'b0;
        data_last_i = 1'b0;
        data_rdy_i  = 1'b1;

        // Word 8'hB2, full length, valid for one cycle
        vecs.push_back(mk(1, 1, 0, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 1, 8'hB2, 8, 1));
        // Partial word 1,1,0 with last -> C0 / 3
        vecs.push_back(mk(1, 1, 0, 1, 0, 8'hB2, 8, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 8'hB2, 8, 1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 8'hC0, 3, 1));
        // Eight ones -> FF / 8
        for (int i = 0; i < 7; i++) vecs.push_back(mk(1, 1, 0, 1, 0, 8'hC0, 3, 1));
        vecs.push_back(mk(1, 1, 0, 1, 1, 8'hFF, 8, 1));
        // Unqualified inputs are ignored
        vecs.push_back(mk(1, 0, 1, 1, 0, 8'hFF, 8, 1));
        // 0x55 with a gap, last on the 8th bit: one full word only
        vecs.push_back(mk(0, 1, 0, 1, 0, 8'hFF, 8, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 8'hFF, 8, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 8'hFF, 8, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 8'hFF, 8, 1));
        vecs.push_back(mk(1, 0, 1, 1, 0, 8'hFF, 8, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 8'hFF, 8, 1));
        vecs.push_back(mk(1, 1, 0, 1, 0, 8'hFF, 8, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 8'hFF, 8, 1));
        vecs.push_back(mk(1, 1, 1, 1, 1, 8'h55, 8, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h55, 8, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h55, 8, 1));
        // Single-bit word -> 80 / 1
        vecs.push_back(mk(1, 1, 1, 1, 1, 8'h80, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 8'h80, 1, 1));

        do_reset("reset0");

        foreach (vecs[k]) begin
            cyc(vecs[k].din, vecs[k].val, vecs[k].last, vecs[k].rdy);
            check($sformatf("vec%0d_val", k),  32'(data_val_o), 32'(vecs[k].e_val));
            check($sformatf("vec%0d_data", k), 32'(data_o),     32'(vecs[k].e_data));
            check($sformatf("vec%0d_len", k),  32'(data_len_o), 32'(vecs[k].e_len));
            check($sformatf("vec%0d_rdy", k),  32'(data_rdy_o), 32'(vecs[k].e_rdy));
        end

        // Stall: A on the output, B completes into an occupied slot
        send_word(8'h5A, 1'b0);
        check("stall_a_val", 32'(data_val_o), 32'd1);
        check("stall_a_data", 32'(data_o), 32'h5A);
        send_word(8'h0F, 1'b0);
        check("stall_rdy_low", 32'(data_rdy_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            check("stall_a_stable", 32'(data_o), 32'h5A);
            check("stall_a_len", 32'(data_len_o), 32'd8);
            check("stall_still_low", 32'(data_rdy_o), 32'd0);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        check("stall_b_data", 32'(data_o), 32'h0F);
        check("stall_b_val", 32'(data_val_o), 32'd1);
        check("stall_rdy_back", 32'(data_rdy_o), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("stall_b_hold", 32'(data_o), 32'h0F);
        check("stall_b_hold_val", 32'(data_val_o), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("stall_b_taken", 32'(data_val_o), 32'd0);

        // Reset mid-word
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1);
        do_reset("reset_mid");
        send_word(8'hA5, 1'b1);
        check("reset_mid_word", 32'(data_o), 32'hA5);
        check("reset_mid_len", 32'(data_len_o), 32'd8);
        check("reset_mid_val", 32'(data_val_o), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset while a word is pending
        send_word(8'h5A, 1'b0);
        send_word(8'h0F, 1'b0);
        check("reset_pend_entered", 32'(data_rdy_o), 32'd0);
        data_rdy_i = 1'b0;
        do_reset("reset_pend");
        data_rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            check("reset_pend_no_stale", 32'(data_val_o), 32'd0);
        end
        send_word(8'h3C, 1'b1);
        check("reset_pend_word", 32'(data_o), 32'h3C);
        check("reset_pend_len", 32'(data_len_o), 32'd8);

        // Randomized streams against the reference model
        do_reset("reset_rand_a");
        run_random(65, 1'b0, "rand_popcount");
        do_reset("reset_rand_b");
        run_random(40, 1'b1, "rand_backpressure");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bit_deserializer.md
# bit_deserializer

Serial-to-parallel front end for the popcount stage. It collects a serial bit stream, MSB first, into WIDTH-bit words. Each completed or early-terminated word goes out on a registered valid/ready output port. When it feeds the popcount block, that block has no backpressure, so `data_rdy_i` is tied high and `data_o`/`data_val_o` connect straight to its `data_i`/`data_val_i`.

## Interface
- `WIDTH`, default 8: output word width, ≥2.
- `clk_i`  in  1: single clock; all logic on its rising edge.
- `srst_i`  in  1: reset, synchronous, active-low.
- `data_i`  in  1: serial data bit.
- `data_val_i`  in  1: `data_i` is valid.
- `data_last_i`  in  1: current bit ends the word early; qualified by `data_val_i`.
- `data_rdy_o`  out  1: block accepts a bit this cycle.
- `data_o`  out  WIDTH: assembled word; first received bit sits at `data_o[WIDTH-1]`.
- `data_len_o`  out  $clog2(WIDTH)+1: number of valid bits in `data_o`, 1..WIDTH.
- `data_val_o`  out  1: `data_o`/`data_len_o` are valid.
- `data_rdy_i`  in  1: consumer accepts the output word.

## Operation
- Accept: a bit is taken on an edge where `data_val_i & data_rdy_o` is true. All inputs are ignored otherwise.
- Assembly: the assembly register shifts left and the new bit enters the LSB. The bit counter `cnt` (0..WIDTH) increments on each accept.
- Word completes on the accepted bit when `cnt+1 == WIDTH` or when `data_last_i = 1`.
  - Partial word of n bits: received bits are left-justified in `data_o[WIDTH-1 -: n]`, the remaining LSBs are 0, and `data_len_o = n`.
  - `data_last_i` on the WIDTH-th bit gives a single full word, `data_len_o = WIDTH`. It is not treated as a second event.
- Output slot is free when `!data_val_o | data_rdy_i`.
- State machine, 2 states:
  - FILL: `data_rdy_o = 1`.
    - On completion with the slot free: load the output register directly, set `data_val_o`, clear assembly and `cnt`, stay in FILL.
    - On completion with the slot occupied: hold the justified word and its length in assembly, go to PEND.
  - PEND: `data_rdy_o = 0`.
    - When the slot is free: transfer the held word to the output, clear assembly and `cnt`, go to FILL.
- Output handshake:
  - `data_val_o` clears on `data_val_o & data_rdy_i` unless a new word loads on the same edge.
  - While `data_val_o & !data_rdy_i`, `data_o` and `data_len_o` are stable.
- Reset (`srst_i = 0` at an edge), including mid-word or in PEND:
  - Partial and pending words are discarded.
  - State goes to FILL, `cnt = 0`.
  - `data_val_o = 0`, `data_o = 0`, `data_len_o = 0`.
  - `data_rdy_o` is forced 0 while `srst_i = 0`, then reads 1 on the first cycle after release.

## Timing
- Latency: the word appears with `data_val_o = 1` in the cycle after the edge that accepted its final bit, provided the slot was free.
- Throughput: with `data_rdy_i = 1` and `data_val_i = 1` held, one bit is accepted every cycle with no bubbles, giving one word every WIDTH cycles.
  - The first bit of the next word is accepted in the same cycle the previous word is presented.
- Stall: if completion hits an occupied slot, `data_rdy_o` drops in the next cycle. It returns high one cycle after the edge where the consumer frees the slot.
- `data_rdy_o` depends only on the state register and `srst_i`. There is no combinational path from `data_rdy_i`.
- All outputs are registered except `data_rdy_o`, which is decoded from the state register and `srst_i`.

## Structure
- Package `bit_deserializer_pkg` holds:
  - the state enum (FILL, PEND);
  - the function `len_w(WIDTH) = $clog2(WIDTH)+1`, used for the `cnt` and `data_len_o` widths.
- Single module, no sub-modules. The left-justify shift for partial words is a local function in the module.

## Test plan
- WIDTH=8, `data_rdy_i=1`, bits 1,0,1,1,0,0,1,0 on consecutive cycles → `data_o=8'hB2`, `data_len_o=8`, `data_val_o` high for exactly 1 cycle, 1 cycle after the 8th bit.
- Bits 1,1,0 with `data_last_i` on the third bit → `data_o=8'hC0`, `data_len_o=3`. The next 8 bits, all 1s, give `8'hFF` with length 8.
- `data_rdy_i=0` while word A=`8'h5A` is on the output and word B=`8'h0F` completes → `data_rdy_o` goes low and A is held stable.
  - Raise `data_rdy_i` for 1 cycle → A handed over, B appears next cycle, `data_rdy_o` high 1 cycle after A's transfer.
- `data_last_i` asserted on the 8th bit → exactly one word with `data_len_o=8`, no spurious zero-length word.
- `srst_i` low after 5 bits and again while in PEND → all outputs 0, stale bits never appear, the next 8 bits form a clean word.
- Chained into the popcount stage (`data_rdy_i=1`), 65 random words with random `data_val_i` gaps → each popcount result equals `$countones` of the serial word sent, in order.
